// File: rtl/mili_seq_tx.sv
// Serial stimulus transmitter for Mealy sequence detectors: parallel load, paced serial shift-out.
// Optional detector match counter is enabled with `define MILI_SEQ_TX_MATCH_CNT_EN.
module mili_seq_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned DIV       = 1,
    parameter int unsigned MSB_FIRST = 0,
    parameter int unsigned IDLE_LVL  = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    output logic             ready,
    output logic             busy,
    output logic             a_out,
    output logic             step_en,
`ifdef MILI_SEQ_TX_MATCH_CNT_EN
    input  logic             y_in,
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             done
);

    localparam int unsigned        DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [LEN_W-1:0]   WIDTH_L  = LEN_W'(WIDTH);
    localparam logic               IDLE_BIT = (IDLE_LVL != 0);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [LEN_W-1:0] bits_q, bits_d;
    logic [DIV_W-1:0] div_q, div_d;

    logic step_last;
    logic head_bit;

    assign step_last = (div_q == DIV_LAST);
    assign head_bit  = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bits_d  = bits_q;
        div_d   = div_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len != '0) begin
                        sr_d    = data;
                        bits_d  = (len > WIDTH_L) ? WIDTH_L : len;
                        div_d   = '0;
                        state_d = StShift;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StShift: begin
                if (step_last) begin
                    // Move the next bit into the head position for the following step.
                    sr_d   = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);
                    div_d  = '0;
                    bits_d = bits_q - LEN_W'(1);
                    if (bits_q == LEN_W'(1)) begin
                        state_d = StDone;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr_q    <= '0;
            bits_q  <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bits_q  <= bits_d;
            div_q   <= div_d;
        end
    end

    // Outputs depend on registers only, so the detector never sees an input-to-output path.
    always_comb begin
        ready   = (state_q == StIdle);
        busy    = (state_q != StIdle);
        done    = (state_q == StDone);
        step_en = (state_q == StShift) && step_last;
        a_out   = (state_q == StShift) ? head_bit : IDLE_BIT;
    end

`ifdef MILI_SEQ_TX_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle && start) begin
            cnt_d = '0;
        end else if (step_en && y_in && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mili_seq_tx.sv
// Directed self-checking bench for mili_seq_tx: one DIV=1 and one DIV=3 instance.
module tb_mili_seq_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    int         checks = 0;
    int         failures = 0;

    logic       start1, ready1, busy1, a1, step1, done1;
    logic [7:0] data1;
    logic [3:0] len1;
    logic       start3, ready3, busy3, a3, step3, done3;
    logic [7:0] data3;
    logic [3:0] len3;

    always #5 clk = ~clk;

`ifdef MILI_SEQ_TX_MATCH_CNT_EN
    logic [7:0] cnt1, cnt3;
    logic       y3 = 1'b0;
    logic       seen0;
    logic       y1;
    // Small Mealy detector: y = a while a 0 has been stepped in since reset.
    assign y1 = seen0 & a1;
    always_ff @(posedge clk) begin
        if (!rst_n) seen0 <= 1'b0;
        else if (step1 && !a1) seen0 <= 1'b1;
    end
`endif

    mili_seq_tx #(.WIDTH(8), .LEN_W(4), .DIV(1), .MSB_FIRST(0), .IDLE_LVL(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .data(data1), .len(len1),
        .ready(ready1), .busy(busy1), .a_out(a1), .step_en(step1),
`ifdef MILI_SEQ_TX_MATCH_CNT_EN
        .y_in(y1), .match_cnt(cnt1),
`endif
        .done(done1)
    );

    mili_seq_tx #(.WIDTH(8), .LEN_W(4), .DIV(3), .MSB_FIRST(0), .IDLE_LVL(1), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .data(data3), .len(len3),
        .ready(ready3), .busy(busy3), .a_out(a3), .step_en(step3),
`ifdef MILI_SEQ_TX_MATCH_CNT_EN
        .y_in(y3), .match_cnt(cnt3),
`endif
        .done(done3)
    );

    task automatic test_reset();
        rst_n = 1'b0; start1 = 1'b1; start3 = 1'b1;
        data1 = 8'hFF; len1 = 4'd8; data3 = 8'hFF; len3 = 4'd8;
        repeat (2) @(negedge clk);
        checks += 10;
        if (ready1 !== 1'b1) begin failures++; $display("FAIL reset_ready1 got=%b exp=1", ready1); end
        if (busy1 !== 1'b0)  begin failures++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
        if (step1 !== 1'b0)  begin failures++; $display("FAIL reset_step1 got=%b exp=0", step1); end
        if (a1 !== 1'b1)     begin failures++; $display("FAIL reset_a1 got=%b exp=1", a1); end
        if (done1 !== 1'b0)  begin failures++; $display("FAIL reset_done1 got=%b exp=0", done1); end
        if (ready3 !== 1'b1) begin failures++; $display("FAIL reset_ready3 got=%b exp=1", ready3); end
        if (busy3 !== 1'b0)  begin failures++; $display("FAIL reset_busy3 got=%b exp=0", busy3); end
        if (step3 !== 1'b0)  begin failures++; $display("FAIL reset_step3 got=%b exp=0", step3); end
        if (a3 !== 1'b1)     begin failures++; $display("FAIL reset_a3 got=%b exp=1", a3); end
        if (done3 !== 1'b0)  begin failures++; $display("FAIL reset_done3 got=%b exp=0", done3); end
`ifdef MILI_SEQ_TX_MATCH_CNT_EN
        checks++;
        if (cnt1 !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt1); end
`endif
        start1 = 1'b0; start3 = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks += 2;
        if (ready1 !== 1'b1) begin failures++; $display("FAIL post_reset_ready1 got=%b exp=1", ready1); end
        if (ready3 !== 1'b1) begin failures++; $display("FAIL post_reset_ready3 got=%b exp=1", ready3); end
    endtask

    task automatic test_div1_lsb();
        logic exp_a [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        start1 = 1'b1; data1 = 8'b0010_1100; len1 = 4'd8;
        @(negedge clk);
        start1 = 1'b0; data1 = 8'h00; len1 = 4'd0;
        for (int c = 1; c <= 8; c++) begin
            checks += 3;
            if (step1 !== 1'b1)      begin failures++; $display("FAIL div1_step c=%0d got=%b exp=1", c, step1); end
            if (a1 !== exp_a[c-1])   begin failures++; $display("FAIL div1_a c=%0d got=%b exp=%b", c, a1, exp_a[c-1]); end
            if (done1 !== 1'b0)      begin failures++; $display("FAIL div1_early_done c=%0d got=%b exp=0", c, done1); end
            @(negedge clk);
        end
        checks += 4;
        if (done1 !== 1'b1) begin failures++; $display("FAIL div1_done got=%b exp=1", done1); end
        if (step1 !== 1'b0) begin failures++; $display("FAIL div1_step_after got=%b exp=0", step1); end
        if (a1 !== 1'b1)    begin failures++; $display("FAIL div1_a_done got=%b exp=1", a1); end
        if (busy1 !== 1'b1) begin failures++; $display("FAIL div1_busy_done got=%b exp=1", busy1); end
        @(negedge clk);
        checks += 2;
        if (done1 !== 1'b0)  begin failures++; $display("FAIL div1_done_once got=%b exp=0", done1); end
        if (ready1 !== 1'b1) begin failures++; $display("FAIL div1_ready got=%b exp=1", ready1); end
    endtask

    task automatic test_div3();
        logic exp_a [3] = '{1'b1, 1'b0, 1'b1};
        logic exp_s;
        start3 = 1'b1; data3 = 8'hA5; len3 = 4'd3;
        @(negedge clk);
        start3 = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            exp_s = ((c % 3) == 0);
            checks += 3;
            if (step3 !== exp_s)           begin failures++; $display("FAIL div3_step c=%0d got=%b exp=%b", c, step3, exp_s); end
            if (a3 !== exp_a[(c-1)/3])     begin failures++; $display("FAIL div3_a c=%0d got=%b exp=%b", c, a3, exp_a[(c-1)/3]); end
            if (busy3 !== 1'b1)            begin failures++; $display("FAIL div3_busy c=%0d got=%b exp=1", c, busy3); end
            // A start during the transfer must be neither captured nor queued.
            if (c == 4) begin start3 = 1'b1; data3 = 8'h00; len3 = 4'd8; end
            if (c == 5) start3 = 1'b0;
            @(negedge clk);
        end
        checks += 2;
        if (done3 !== 1'b1) begin failures++; $display("FAIL div3_done got=%b exp=1", done3); end
        if (step3 !== 1'b0) begin failures++; $display("FAIL div3_step_done got=%b exp=0", step3); end
        @(negedge clk);
        checks++;
        if (ready3 !== 1'b1) begin failures++; $display("FAIL div3_ready got=%b exp=1", ready3); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks += 2;
            if (busy3 !== 1'b0) begin failures++; $display("FAIL div3_queued_busy c=%0d got=%b exp=0", c, busy3); end
            if (step3 !== 1'b0) begin failures++; $display("FAIL div3_queued_step c=%0d got=%b exp=0", c, step3); end
        end
    endtask

    task automatic test_len_bounds();
        start1 = 1'b1; data1 = 8'hFF; len1 = 4'd0;
        @(negedge clk);
        start1 = 1'b0;
        checks += 3;
        if (done1 !== 1'b1) begin failures++; $display("FAIL len0_done got=%b exp=1", done1); end
        if (step1 !== 1'b0) begin failures++; $display("FAIL len0_step got=%b exp=0", step1); end
        if (a1 !== 1'b1)    begin failures++; $display("FAIL len0_a got=%b exp=1", a1); end
        @(negedge clk);
        checks += 3;
        if (done1 !== 1'b0)  begin failures++; $display("FAIL len0_done_once got=%b exp=0", done1); end
        if (ready1 !== 1'b1) begin failures++; $display("FAIL len0_ready got=%b exp=1", ready1); end
        if (step1 !== 1'b0)  begin failures++; $display("FAIL len0_step2 got=%b exp=0", step1); end

        start1 = 1'b1; data1 = 8'hFF; len1 = 4'd12;
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks += 2;
            if (step1 !== 1'b1) begin failures++; $display("FAIL len12_step c=%0d got=%b exp=1", c, step1); end
            if (a1 !== 1'b1)    begin failures++; $display("FAIL len12_a c=%0d got=%b exp=1", c, a1); end
            @(negedge clk);
        end
        checks += 2;
        if (step1 !== 1'b0) begin failures++; $display("FAIL len12_ninth_step got=%b exp=0", step1); end
        if (done1 !== 1'b1) begin failures++; $display("FAIL len12_done got=%b exp=1", done1); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        start1 = 1'b1; data1 = 8'h00; len1 = 4'd8;
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (step1 !== 1'b1) begin failures++; $display("FAIL midrst_step c=%0d got=%b exp=1", c, step1); end
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks += 5;
        if (ready1 !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ready1); end
        if (busy1 !== 1'b0)  begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy1); end
        if (step1 !== 1'b0)  begin failures++; $display("FAIL midrst_step got=%b exp=0", step1); end
        if (a1 !== 1'b1)     begin failures++; $display("FAIL midrst_a got=%b exp=1", a1); end
        if (done1 !== 1'b0)  begin failures++; $display("FAIL midrst_done got=%b exp=0", done1); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks += 2;
            if (step1 !== 1'b0) begin failures++; $display("FAIL midrst_late_step c=%0d got=%b exp=0", c, step1); end
            if (done1 !== 1'b0) begin failures++; $display("FAIL midrst_late_done c=%0d got=%b exp=0", c, done1); end
        end
    endtask

`ifdef MILI_SEQ_TX_MATCH_CNT_EN
    task automatic test_match_cnt();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start1 = 1'b1; data1 = 8'b0000_1110; len1 = 4'd4;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        checks += 2;
        if (done1 !== 1'b1)  begin failures++; $display("FAIL match_done got=%b exp=1", done1); end
        if (cnt1 !== 8'd3)   begin failures++; $display("FAIL match_cnt got=%0d exp=3", cnt1); end
        @(negedge clk);
        checks++;
        if (cnt1 !== 8'd3)   begin failures++; $display("FAIL match_hold got=%0d exp=3", cnt1); end
        start1 = 1'b1; data1 = 8'h00; len1 = 4'd2;
        @(negedge clk);
        start1 = 1'b0;
        checks++;
        if (cnt1 !== 8'd0)   begin failures++; $display("FAIL match_clear got=%0d exp=0", cnt1); end
        repeat (4) @(negedge clk);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        start1 = 1'b0; data1 = '0; len1 = '0;
        start3 = 1'b0; data3 = '0; len3 = '0;
        @(negedge clk);
        test_reset();
        test_div1_lsb();
        test_div3();
        test_len_bounds();
        test_reset_mid_shift();
`ifdef MILI_SEQ_TX_MATCH_CNT_EN
        test_match_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mili_seq_tx.md
Name: mili_seq_tx

Overview:
Serial stimulus transmitter for the team's Mealy sequence-detector blocks. It drives a detector's `a` input and its `en` step strobe.
- Loads a parallel word on a start/ready handshake.
- Shifts the word out one bit per step, with a programmable number of clocks per step.
- Signals completion with a one-cycle done pulse.
- Sits upstream of the detector, in test harnesses or as the on-chip pattern source.

Parameters:
WIDTH, 8, shift-word width in bits (>=1)
LEN_W, 4, width of the len input; must satisfy 2^LEN_W > WIDTH
DIV, 1, clocks per step (>=1); step_en asserts once every DIV clocks while shifting
MSB_FIRST, 0, 0 = bit 0 transmitted first, 1 = bit WIDTH-1 transmitted first
IDLE_LVL, 1, level of a_out when not shifting (1 keeps a detector parked in its reset state)
CNT_W, 8, match counter width (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  request to transmit; accepted when start & ready
data  in  WIDTH  word to transmit, captured on acceptance
len  in  LEN_W  number of bits to send, captured on acceptance; values above WIDTH are clamped to WIDTH
ready  out  1  high only in IDLE
busy  out  1  high in SHIFT and DONE
a_out  out  1  serial bit to the detector's a input
step_en  out  1  one-clock step strobe to the detector's en input
done  out  1  one-clock pulse after the last step

Behaviour:
Clock and reset:
- Single clock domain.
- rst_n is synchronous, active-low, and overrides everything.

Reset values:
- state = IDLE, ready = 1, busy = 0, done = 0, step_en = 0.
- a_out = IDLE_LVL; shift register, bit counter and divider counter = 0.

State machine: IDLE, SHIFT, DONE. Registers are the state, shift register, bit counter and divider counter; outputs are decoded from these registers only, with no input-to-output paths.

IDLE:
- Outputs: ready = 1, a_out = IDLE_LVL.
- start & len != 0:
  - capture data;
  - bits = min(len, WIDTH);
  - div counter = 0;
  - go to SHIFT.
- start & len == 0: go to DONE directly; no step is emitted.

SHIFT:
- a_out = current head bit of the shift register: bit 0, or bit WIDTH-1 if MSB_FIRST.
- a_out is held stable for the whole step period.
- Div counter counts 0..DIV-1.
- step_en = 1 while the counter equals DIV-1.
- On that edge:
  - shift the register one place toward the head;
  - reload the div counter to 0;
  - decrement bits.
- If bits was 1 on that edge, go to DONE.

DONE:
- done = 1 and a_out = IDLE_LVL for exactly one cycle.
- Then go to IDLE.

Timing (start accepted on edge E0):
- step k (k = 1..n) is sampled by the consumer on edge E0 + k*DIV.
- done is high during the cycle after edge E0 + n*DIV.
- ready returns the cycle after that.
- With DIV = 1, step_en is high continuously for n cycles.
- With len = 0, done is high during the cycle after E0.

Boundary conditions:
- start while busy is ignored; no re-capture, no queueing.
- data and len may change freely after capture.
- rst_n low mid-SHIFT: at the next edge, return to reset values; no done pulse is produced.
- Only the low min(len, WIDTH) bits in transmission order are sent; the remaining bits are discarded.

Optional Feature:
Macro: MILI_SEQ_TX_MATCH_CNT_EN

Defined:
- Adds port y_in (in, 1): the detector's Mealy output.
- Adds port match_cnt (out, CNT_W).
- match_cnt:
  - clears to 0 on accepted start and on reset;
  - increments on every cycle with step_en & y_in;
  - saturates at 2^CNT_W - 1;
  - holds its value after done until the next accepted start.

Undefined:
- Neither port exists.
- No counter logic is present.

Test Plan:
1. Reset: hold rst_n low for 2 clocks with start = 1 -> ready = 1, busy = 0, step_en = 0, a_out = 1, done = 0; start is not accepted during reset.
2. DIV = 1, MSB_FIRST = 0, data = 8'b0010_1100, len = 8 -> step_en high for 8 consecutive cycles; a_out = 0,0,1,1,0,1,0,0; done pulses once, the cycle after the 8th step.
3. DIV = 3, data = 8'hA5, len = 3 -> steps on E0+3, E0+6 and E0+9 with a_out = 1,0,1; a_out is stable for 3 clocks per bit; start pulses mid-transfer are ignored.
4. len = 0 -> no step_en; done high during the cycle after acceptance; len = 12 with WIDTH = 8 -> exactly 8 steps.
5. rst_n low after the 2nd step of an 8-bit transfer -> next cycle shows IDLE reset values, no further step_en, no done.
6. With MILI_SEQ_TX_MATCH_CNT_EN, transmitter connected to the team's Mealy detector, data = 4'b1110, len = 4, DIV = 1 -> bits 0,1,1,1 produce y on steps 2 to 4, so match_cnt = 3 after done; a new start clears it to 0.
